// File: rtl/demux_1x4_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module : demux_1x4_stream_pkg
//  Brief  : Shared channel constants and helpers for the 1:4 stream demux
//  Rev    : 1.0  initial release
// ============================================================================
package demux_1x4_stream_pkg;

    localparam logic [1:0] CH0    = 2'd0;
    localparam logic [1:0] CH1    = 2'd1;
    localparam logic [1:0] CH2    = 2'd2;
    localparam logic [1:0] CH3    = 2'd3;
    localparam int         NUM_CH = 4;

    // Next round-robin channel; the 2-bit add wraps 3 -> 0 naturally
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return ch + 2'd1;
    endfunction

endpackage : demux_1x4_stream_pkg
`default_nettype wire

// File: rtl/demux_1x4_stream_if.sv
`default_nettype none
// ============================================================================
//  Module : demux_1x4_stream_if
//  Brief  : Input stream plus four output channels of the 1:4 stream demux
//  Rev    : 1.0  initial release
// ============================================================================
interface demux_1x4_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_select;
    logic [DATA_WIDTH-1:0] in_data;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [DATA_WIDTH-1:0] out0_data;
    logic [DATA_WIDTH-1:0] out1_data;
    logic [DATA_WIDTH-1:0] out2_data;
    logic [DATA_WIDTH-1:0] out3_data;
    logic [1:0]            rr_ptr;
    logic                  busy;

    // Producer/consumer side (drives the input word and the consumer readies)
    modport master (
        output in_valid, in_select, in_data, out_ready,
        input  in_ready, out_valid, out0_data, out1_data, out2_data, out3_data,
               rr_ptr, busy
    );

    // Demux side
    modport slave (
        input  in_valid, in_select, in_data, out_ready,
        output in_ready, out_valid, out0_data, out1_data, out2_data, out3_data,
               rr_ptr, busy
    );
endinterface : demux_1x4_stream_if
`default_nettype wire

// File: rtl/demux_1x4_stream_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module : demux_hold_reg
//  Brief  : One-entry holding slot for a single demux output channel
//  Rev    : 1.0  initial release
// ============================================================================
module demux_hold_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  load_i,
    input  wire logic [DATA_WIDTH-1:0] data_i,
    input  wire logic                  drain_i,
    output logic                       valid_o,
    output logic [DATA_WIDTH-1:0]      data_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Load has priority so a simultaneous drain+load keeps the slot full;
    // a drain only clears valid, the last word stays visible on data_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (drain_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : demux_hold_reg
`default_nettype wire

// File: rtl/demux_1x4_stream.sv
`default_nettype none
// ============================================================================
//  Module : demux_1x4_stream
//  Brief  : Registered 1:4 valid/ready stream demux, select or round-robin
//  Rev    : 1.0  initial release
// ============================================================================
module demux_1x4_stream
    import demux_1x4_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter bit RR_MODE    = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    demux_1x4_stream_if.slave  bus
);

    logic [1:0]            rr_ptr_q;
    logic [1:0]            rr_ptr_d;
    logic [1:0]            w_target;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [NUM_CH-1:0]     w_valid;
    logic [NUM_CH-1:0]     w_load;
    logic [DATA_WIDTH-1:0] w_data [NUM_CH];

    // Target slot may take a word if empty or emptying this very cycle
    assign w_target   = RR_MODE ? rr_ptr_q : bus.in_select;
    assign w_in_ready = ~w_valid[w_target] | bus.out_ready[w_target];
    assign w_accept   = bus.in_valid & w_in_ready;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_load[g] = w_accept & (w_target == 2'(g));

            demux_hold_reg #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .load_i  (w_load[g]),
                .data_i  (bus.in_data),
                .drain_i (bus.out_ready[g]),
                .valid_o (w_valid[g]),
                .data_o  (w_data[g])
            );
        end
    endgenerate

    // Round-robin pointer advances only on an accepted word (strict order)
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (RR_MODE && w_accept) begin
            rr_ptr_d = next_ch(rr_ptr_q);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= CH0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out0_data = w_data[0];
    assign bus.out1_data = w_data[1];
    assign bus.out2_data = w_data[2];
    assign bus.out3_data = w_data[3];
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.busy      = |w_valid;

endmodule : demux_1x4_stream
`default_nettype wire

// File: tb/tb_demux_1x4_stream.sv
`default_nettype none
// ============================================================================
//  Module : tb_demux_1x4_stream
//  Brief  : Self-checking bench; select-mode and round-robin DUTs share stimulus
//  Rev    : 1.0  initial release
// ============================================================================
module tb_demux_1x4_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_select = 2'd0;
    logic [15:0] in_data = 16'h0;
    logic [3:0]  out_ready = 4'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_1x4_stream_if #(.DATA_WIDTH(16)) bus0 ();
    demux_1x4_stream_if #(.DATA_WIDTH(16)) bus1 ();

    demux_1x4_stream #(.DATA_WIDTH(16), .RR_MODE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    demux_1x4_stream #(.DATA_WIDTH(16), .RR_MODE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.in_valid  = in_valid;
    assign bus0.in_select = in_select;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_select = in_select;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = out_ready;

    // Observed DUT outputs, indexed [mode]
    logic [3:0]  d_ov   [2];
    logic        d_irdy [2];
    logic [1:0]  d_rr   [2];
    logic        d_busy [2];
    logic [15:0] d_data [2][4];

    assign d_ov[0] = bus0.out_valid;   assign d_ov[1] = bus1.out_valid;
    assign d_irdy[0] = bus0.in_ready;  assign d_irdy[1] = bus1.in_ready;
    assign d_rr[0] = bus0.rr_ptr;      assign d_rr[1] = bus1.rr_ptr;
    assign d_busy[0] = bus0.busy;      assign d_busy[1] = bus1.busy;
    assign d_data[0][0] = bus0.out0_data; assign d_data[0][1] = bus0.out1_data;
    assign d_data[0][2] = bus0.out2_data; assign d_data[0][3] = bus0.out3_data;
    assign d_data[1][0] = bus1.out0_data; assign d_data[1][1] = bus1.out1_data;
    assign d_data[1][2] = bus1.out2_data; assign d_data[1][3] = bus1.out3_data;

    // Reference model: per mode, each channel is a one-word mailbox
    bit          m_full [2][4];
    logic [15:0] m_word [2][4];
    int          m_rr   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [3:0] exp_ov;
            int         tgt;
            bit         exp_irdy;
            for (int n = 0; n < 4; n++) exp_ov[n] = m_full[m][n];
            tgt      = (m == 1) ? m_rr[m] : int'(in_select);
            exp_irdy = !m_full[m][tgt] || out_ready[tgt];
            chk($sformatf("m%0d out_valid", m), 32'(d_ov[m]), 32'(exp_ov));
            chk($sformatf("m%0d in_ready", m), 32'(d_irdy[m]), 32'(exp_irdy));
            chk($sformatf("m%0d busy", m), 32'(d_busy[m]), 32'(exp_ov != 4'h0));
            chk($sformatf("m%0d rr_ptr", m), 32'(d_rr[m]), (m == 1) ? 32'(m_rr[m]) : 32'd0);
            for (int n = 0; n < 4; n++)
                chk($sformatf("m%0d out%0d_data", m, n), 32'(d_data[m][n]), 32'(m_word[m][n]));
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int n = 0; n < 4; n++) begin
                    m_full[m][n] = 1'b0;
                    m_word[m][n] = 16'h0;
                end
                m_rr[m] = 0;
            end else begin
                int tgt;
                bit acc;
                tgt = (m == 1) ? m_rr[m] : int'(in_select);
                acc = in_valid && (!m_full[m][tgt] || out_ready[tgt]);
                for (int n = 0; n < 4; n++)
                    if (out_ready[n]) m_full[m][n] = 1'b0;
                if (acc) begin
                    m_full[m][tgt] = 1'b1;
                    m_word[m][tgt] = in_data;
                    if (m == 1) m_rr[m] = (m_rr[m] + 1) % 4;
                end
            end
        end
    endtask

    task automatic at_negedge();
        @(negedge clk);
        check_all();
    endtask

    task automatic at_posedge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [15:0] d;
        logic [3:0]  ordy;
        logic [3:0]  ov;     // select-mode out_valid before the edge
        logic        irdy;   // select-mode in_ready before the edge
        int          ch;
        logic [15:0] chd;    // that channel's data before the edge
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 16'h1111, 4'hF, 4'b0000, 1'b1, 2, 16'h0000};
        tbl[1]  = '{1'b0, 2'd2, 16'h0000, 4'hF, 4'b0100, 1'b1, 2, 16'h1111};
        tbl[2]  = '{1'b0, 2'd2, 16'h0000, 4'hF, 4'b0000, 1'b1, 2, 16'h1111};
        tbl[3]  = '{1'b1, 2'd1, 16'hAAAA, 4'h0, 4'b0000, 1'b1, 1, 16'h0000};
        tbl[4]  = '{1'b1, 2'd1, 16'hBBBB, 4'h0, 4'b0010, 1'b0, 1, 16'hAAAA};
        tbl[5]  = '{1'b1, 2'd1, 16'hBBBB, 4'h0, 4'b0010, 1'b0, 1, 16'hAAAA};
        tbl[6]  = '{1'b1, 2'd1, 16'hBBBB, 4'b0010, 4'b0010, 1'b1, 1, 16'hAAAA};
        tbl[7]  = '{1'b1, 2'd3, 16'h3333, 4'h0, 4'b0010, 1'b1, 1, 16'hBBBB};
        tbl[8]  = '{1'b0, 2'd0, 16'h0000, 4'h0, 4'b1010, 1'b1, 3, 16'h3333};
        tbl[9]  = '{1'b0, 2'd1, 16'h0000, 4'h0, 4'b1010, 1'b0, 1, 16'hBBBB};
        tbl[10] = '{1'b0, 2'd0, 16'h0000, 4'b0100, 4'b1010, 1'b1, 2, 16'h1111};
        tbl[11] = '{1'b0, 2'd0, 16'h0000, 4'hF, 4'b1010, 1'b1, 3, 16'h3333};
        tbl[12] = '{1'b0, 2'd0, 16'h0000, 4'h0, 4'b0000, 1'b1, 1, 16'hBBBB};

        // Reset for two cycles
        rst = 1'b1;
        at_posedge();
        at_posedge();
        rst = 1'b0;
        at_negedge();
        chk("reset in_ready", 32'(d_irdy[0]), 32'd1);
        chk("reset busy", 32'(d_busy[0]), 32'd0);
        chk("reset out_valid", 32'(d_ov[0]), 32'd0);
        at_posedge();

        // Directed select-mode sequences from a table
        for (int i = 0; i < 13; i++) begin
            in_valid  = tbl[i].iv;
            in_select = tbl[i].sel;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            at_negedge();
            chk($sformatf("vec%0d out_valid", i), 32'(d_ov[0]), 32'(tbl[i].ov));
            chk($sformatf("vec%0d in_ready", i), 32'(d_irdy[0]), 32'(tbl[i].irdy));
            chk($sformatf("vec%0d ch%0d data", i, tbl[i].ch), 32'(d_data[0][tbl[i].ch]), 32'(tbl[i].chd));
            at_posedge();
        end

        // Round-robin: six words land on ch0,1,2,3,0,1
        in_valid = 1'b0;
        out_ready = 4'hF;
        rst = 1'b1;
        at_posedge();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 6);
            in_data  = 16'(i);
            at_negedge();
            chk($sformatf("rr word%0d rr_ptr", i), 32'(d_rr[1]), 32'(i % 4));
            if (i > 0) begin
                chk($sformatf("rr word%0d out_valid", i - 1), 32'(d_ov[1]), 32'(4'b0001 << ((i - 1) % 4)));
                chk($sformatf("rr word%0d data", i - 1), 32'(d_data[1][(i - 1) % 4]), 32'(i - 1));
            end
            at_posedge();
        end

        // Reset mid-stream with two select-mode slots full
        in_valid  = 1'b1;
        out_ready = 4'h0;
        in_select = 2'd1;
        in_data   = 16'h5151;
        at_negedge();
        at_posedge();
        in_select = 2'd2;
        in_data   = 16'h5252;
        at_negedge();
        at_posedge();
        in_valid = 1'b0;
        at_negedge();
        chk("midreset pre out_valid", 32'(d_ov[0]), 32'b0110);
        rst = 1'b1;
        at_posedge();
        rst = 1'b0;
        at_negedge();
        chk("midreset out_valid m0", 32'(d_ov[0]), 32'd0);
        chk("midreset out_valid m1", 32'(d_ov[1]), 32'd0);
        chk("midreset rr_ptr", 32'(d_rr[1]), 32'd0);
        at_posedge();

        // Random traffic against the mailbox model, with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_select = 2'($urandom_range(0, 3));
            in_data   = 16'($urandom);
            out_ready = 4'($urandom);
            at_negedge();
            at_posedge();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux_1x4_stream
`default_nettype wire
